ccff_chain_loader: RTL

Synthesizable configuration-chain programmer for `fpga_top`. It accepts the bitstream as a valid/ready stream of columns, one bit per chain per beat, and shifts it into the `ccff_head` inputs of all configuration chains in parallel. In an optional second pass it shifts the same bitstream again and compares `ccff_tail` against the first pass to confirm the configuration was loaded. It replaces the testbench's direct bitstream forcing with the on-chip writer and checker for the same chain.

---
 rtl/ccff_chain_loader.sv | 86 ++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams a bitstream into parallel configuration chains and optionally verifies it
module ccff_chain_loader #(
    parameter int NUM_CHAINS = 10,
    parameter int CHAIN_LEN  = 1024,
    parameter int ERR_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  verify_en,
    input  logic [NUM_CHAINS-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [NUM_CHAINS-1:0] ccff_head,
    output logic                  prog_clock_en,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);
    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, FIN, DONE} state_t;
    state_t                r_state;
    logic                  r_vfy;
    logic                  r_chk;
    logic [CW-1:0]         r_cnt;
    logic [NUM_CHAINS-1:0] r_exp;
    logic                  w_acc;
    logic                  w_last;
    logic                  w_mis;
    logic [ERR_W-1:0]      w_err_next;
    assign cfg_ready  = (r_state == LOAD) || (r_state == VERIFY);
    assign busy       = cfg_ready;
    assign w_acc      = cfg_valid && cfg_ready;
    assign w_last     = r_cnt == LAST;
    // r_chk marks the shift cycle of a verify beat; the tail then holds the pass-1 beat at that index
    assign w_mis      = r_chk && (ccff_tail != r_exp);
    assign w_err_next = err_count + ERR_W'(w_mis && !(&err_count));
    // Sequencer: shifts accepted beats, counts tail mismatches, reports the result in DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_vfy         <= 1'b0;
            r_chk         <= 1'b0;
            r_cnt         <= '0;
            r_exp         <= '0;
            ccff_head     <= '0;
            prog_clock_en <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
        end else begin
            prog_clock_en <= w_acc;
            r_chk         <= w_acc && (r_state == VERIFY);
            done          <= 1'b0;
            err_count     <= w_err_next;
            if (w_acc) begin
                ccff_head <= cfg_data;
                r_exp     <= cfg_data;
                r_cnt     <= r_cnt + 1'b1;
            end
            case (r_state)
                IDLE: if (start) begin
                    r_state   <= LOAD;
                    r_vfy     <= verify_en;
                    r_cnt     <= '0;
                    err_count <= '0;
                    pass      <= 1'b0;
                end
                LOAD: if (w_acc && w_last) begin
                    r_state <= r_vfy ? VERIFY : FIN;
                    r_cnt   <= '0;
                end
                VERIFY: if (w_acc && w_last) r_state <= FIN;
                FIN: begin
                    done    <= 1'b1;
                    pass    <= !r_vfy || (w_err_next == '0);
                    r_state <= DONE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
